// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined logic unit: opcode width and opcode encodings.
// Opcodes 000-011 keep the legacy {s0,s1} meaning of the original 8-bit unit.
package logic_unit_pkg;

  // Opcode width; the core decode assumes exactly 3 bits.
  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_OR   = 3'b000;
  localparam logic [OP_W-1:0] OP_AND  = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
  localparam logic [OP_W-1:0] OP_NOTX = 3'b011;
  localparam logic [OP_W-1:0] OP_NOR  = 3'b100;
  localparam logic [OP_W-1:0] OP_NAND = 3'b101;
  localparam logic [OP_W-1:0] OP_XNOR = 3'b110;
  localparam logic [OP_W-1:0] OP_PASS = 3'b111;

endpackage

// File: rtl/logic_unit_core.sv
// Purely combinational WIDTH-bit logic function: (x, y, op) -> result.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic [OP_W-1:0]  i_op,
  output logic [WIDTH-1:0] o_res
);

  // Decode the opcode into one bitwise operation.
  always_comb begin
    o_res = '0;
    unique case (i_op)
      OP_OR:   o_res = i_x | i_y;
      OP_AND:  o_res = i_x & i_y;
      OP_XOR:  o_res = i_x ^ i_y;
      OP_NOTX: o_res = ~i_x;
      OP_NOR:  o_res = ~(i_x | i_y);
      OP_NAND: o_res = ~(i_x & i_y);
      OP_XNOR: o_res = ~(i_x ^ i_y);
      OP_PASS: o_res = i_x;
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipelined logic unit with result flags.
// S1 registers the core result on accept; S2 registers it onto f and drives out_valid.
// Flags are decoded from the registered f only, so they never see operand X's.
// Optional accumulator (use_acc port, y replaced by last result) under LOGIC_UNIT_PIPE_ACC_EN.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 8,
  // Fixed at 3; the core decode is written for 3-bit opcodes.
  parameter int unsigned OP_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [OP_W-1:0]  op,
`ifdef LOGIC_UNIT_PIPE_ACC_EN
  input  logic             use_acc,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             zero,
  output logic             ones,
  output logic             parity
);

  import logic_unit_pkg::*;

  logic             w_accept;
  logic             w_adv2;
  logic [WIDTH-1:0] w_y_eff;
  logic [WIDTH-1:0] w_res;

  logic             r_s1_v;
  logic [WIDTH-1:0] r_s1_res;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_f;

  // S1 moves into S2 whenever S2 is empty or being drained this cycle.
  assign w_adv2   = r_s1_v && (!r_out_valid || out_ready);
  assign in_ready = !r_s1_v || w_adv2;
  assign w_accept = in_valid && in_ready;

`ifdef LOGIC_UNIT_PIPE_ACC_EN
  logic [WIDTH-1:0] r_acc;

  assign w_y_eff = use_acc ? r_acc : y;

  // Accumulator follows every accepted result, independent of output backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_accept) begin
      r_acc <= w_res;
    end
  end
`else
  assign w_y_eff = y;
`endif

  logic_unit_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_x   (x),
    .i_y   (w_y_eff),
    .i_op  (op[2:0]),
    .o_res (w_res)
  );

  // Stage 1: capture the result of an accepted beat; empty out when it advances alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v   <= 1'b0;
      r_s1_res <= '0;
    end else if (w_accept) begin
      // Also covers simultaneous accept/advance: S1 stays full with the new beat.
      r_s1_v   <= 1'b1;
      r_s1_res <= w_res;
    end else if (w_adv2) begin
      r_s1_v   <= 1'b0;
    end
  end

  // Stage 2: load from S1 on advance; drop valid once consumed; hold f while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_f         <= '0;
    end else if (w_adv2) begin
      r_out_valid <= 1'b1;
      r_f         <= r_s1_res;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign f         = r_f;
  assign zero      = (r_f == '0);
  assign ones      = &r_f;
  assign parity    = ^r_f;

endmodule
